bmp_pixel_serializer: RTL and testbench



---
 rtl/bmp_pixel_serializer_pkg.sv | 13 +
 rtl/bmp_pixel_serializer_row_counter.sv | 38 +++
 rtl/bmp_pixel_serializer.sv | 133 +++++++++++++
 tb/tb_bmp_pixel_serializer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmp_pixel_serializer_pkg.sv
// Shared constants for the BMP pixel-array serializer/deserializer pair.
// The width helper keeps counters at least one bit wide for degenerate sizes.
package bmp_pixel_serializer_pkg;

    localparam int DEF_PIXEL_SIZE   = 24;
    localparam int DEF_CHANNEL_SIZE = 8;
    localparam int BYTES_PER_PIXEL  = 3;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bmp_pixel_serializer_row_counter.sv
// Column/row position tracker for a BMP pixel array.
// Raises row_end on the last column and frame_end on the last row.
module bmp_row_counter
    import bmp_pixel_serializer_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic clk,
    input  logic reset,
    input  logic col_adv,
    input  logic row_adv,
    output logic row_end,
    output logic frame_end
);

    localparam int CW = cnt_width(IMG_WIDTH);
    localparam int RW = cnt_width(IMG_HEIGHT);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    assign row_end   = (col == CW'(IMG_WIDTH - 1));
    assign frame_end = (row == RW'(IMG_HEIGHT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else begin
            if (col_adv)
                col <= row_end ? '0 : col + CW'(1);
            if (row_adv)
                row <= frame_end ? '0 : row + RW'(1);
        end
    end

endmodule

// File: rtl/bmp_pixel_serializer.sv
// Turns a stream of 24-bit pixels into BMP pixel-array bytes, low byte first,
// zero-padding each row to a 4-byte multiple and flagging the frame's last byte.
module bmp_pixel_serializer
    import bmp_pixel_serializer_pkg::*;
#(
    parameter int IMG_WIDTH    = 640,
    parameter int IMG_HEIGHT   = 480,
    parameter int PIXEL_SIZE   = DEF_PIXEL_SIZE,
    parameter int CHANNEL_SIZE = DEF_CHANNEL_SIZE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [PIXEL_SIZE-1:0]   in_pixel,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [CHANNEL_SIZE-1:0] out_byte,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    frame_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_PAD  = 2'd2;

    localparam int         NUM_PAD  = IMG_WIDTH % 4;
    localparam bit         HAS_PAD  = (NUM_PAD != 0);
    localparam logic [1:0] PAD_LAST = HAS_PAD ? 2'(NUM_PAD - 1) : 2'd0;
    localparam logic [1:0] IDX_LAST = 2'(BYTES_PER_PIXEL - 1);

    logic [1:0]              state, state_nxt;
    logic [1:0]              idx;
    logic [1:0]              pad_cnt;
    logic [PIXEL_SIZE-1:0]   held;
    logic [CHANNEL_SIZE-1:0] held_byte;
    logic in_fire, out_fire, pix_done, pad_done;
    logic row_end, frame_end, row_adv;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign pix_done = out_fire && (state == S_SEND) && (idx == IDX_LAST);
    assign pad_done = out_fire && (state == S_PAD) && (pad_cnt == PAD_LAST);
    // Row closes on its final byte: the last pad byte, or the last pixel byte when unpadded.
    assign row_adv  = (pix_done && row_end && !HAS_PAD) || pad_done;

    bmp_row_counter #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT)
    ) u_pos (
        .clk      (clk),
        .reset    (reset),
        .col_adv  (pix_done),
        .row_adv  (row_adv),
        .row_end  (row_end),
        .frame_end(frame_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (in_fire) state_nxt = S_SEND;
            S_SEND: begin
                if (pix_done) begin
                    if (row_end && HAS_PAD) state_nxt = S_PAD;
                    else if (in_fire)       state_nxt = S_SEND;
                    else                    state_nxt = S_IDLE;
                end
            end
            S_PAD:   if (pad_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        held_byte = '0;
        case (idx)
            2'd0:    held_byte = held[0 +: CHANNEL_SIZE];
            2'd1:    held_byte = held[CHANNEL_SIZE +: CHANNEL_SIZE];
            2'd2:    held_byte = held[2*CHANNEL_SIZE +: CHANNEL_SIZE];
            default: held_byte = '0;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_byte  = '0;
        out_last  = 1'b0;
        case (state)
            S_IDLE: in_ready = 1'b1;
            S_SEND: begin
                out_valid = 1'b1;
                out_byte  = held_byte;
                // Accept the next pixel in the same cycle its predecessor drains.
                in_ready  = out_ready && (idx == IDX_LAST) && (!row_end || !HAS_PAD);
                out_last  = (idx == IDX_LAST) && row_end && frame_end && !HAS_PAD;
            end
            S_PAD: begin
                out_valid = 1'b1;
                out_last  = (pad_cnt == PAD_LAST) && frame_end;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held       <= '0;
            idx        <= '0;
            pad_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_fire && out_last;
            if (in_fire) begin
                held <= in_pixel;
                idx  <= '0;
            end else if (pix_done) begin
                idx  <= '0;
            end else if (out_fire && (state == S_SEND)) begin
                idx  <= idx + 2'd1;
            end
            if (state != S_PAD || pad_done) pad_cnt <= '0;
            else if (out_fire)              pad_cnt <= pad_cnt + 2'd1;
        end
    end

endmodule

// File: tb/tb_bmp_pixel_serializer.sv
// Bench for bmp_pixel_serializer: several image geometries, a queue-based byte model
// derived from pixel order, and literal checks on byte streams and frame timing.
module tb_bmp_pixel_serializer;

    localparam int NT = 5;

    function automatic int tw(input int k);
        case (k)
            0: return 4;
            1: return 3;
            2: return 1;
            3: return 2;
            default: return 5;
        endcase
    endfunction

    function automatic int th(input int k);
        case (k)
            0: return 2;
            1: return 1;
            2: return 1;
            3: return 2;
            default: return 3;
        endcase
    endfunction

    typedef struct {
        logic [7:0] b;
        bit         last;
        bit         pad;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid_a  [NT];
    logic [23:0] in_pixel_a  [NT];
    logic        out_ready_a [NT];
    wire         in_ready_a  [NT];
    wire         out_valid_a [NT];
    wire  [7:0]  out_byte_a  [NT];
    wire         out_last_a  [NT];
    wire         frame_done_a[NT];

    for (genvar k = 0; k < NT; k++) begin : g_dut
        bmp_pixel_serializer #(
            .IMG_WIDTH (tw(k)),
            .IMG_HEIGHT(th(k))
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid_a[k]),
            .in_pixel  (in_pixel_a[k]),
            .in_ready  (in_ready_a[k]),
            .out_valid (out_valid_a[k]),
            .out_byte  (out_byte_a[k]),
            .out_ready (out_ready_a[k]),
            .out_last  (out_last_a[k]),
            .frame_done(frame_done_a[k])
        );
    end

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cur = 0;
    int          cyc = 0;
    ent_t        q[$];
    logic [23:0] src[$];
    int          blog[$];
    int          last_idx[$];
    int          fd_xfer[$];
    int          ifire[$];
    int          pix_n = 0;
    int          idle_cnt = 0;
    bit          fd_exp = 0;
    bit          in_fired = 0;
    bit          stall = 0;
    logic [7:0]  stall_byte = 8'h00;
    int          or_mode = 0;
    int          gapn = 0;
    bit          rnd_gap = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (inst %0d, cycle %0d)", nm, act, exp, cur, cyc);
        end
    endtask

    // Reference model: every accepted pixel expands to its three bytes plus the row's
    // trailing zero pad when it closes a row; the last entry of a frame carries last.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            chk("rst_out_valid", out_valid_a[cur], 0);
            chk("rst_out_byte", out_byte_a[cur], 0);
            chk("rst_out_last", out_last_a[cur], 0);
            chk("rst_frame_done", frame_done_a[cur], 0);
            chk("rst_in_ready", in_ready_a[cur], 1);
            q.delete(); blog.delete(); last_idx.delete(); fd_xfer.delete(); ifire.delete();
            pix_n = 0; fd_exp = 0; in_fired = 0; stall = 0; idle_cnt = 0;
        end else begin
            chk("frame_done", frame_done_a[cur], int'(fd_exp));
            if (frame_done_a[cur]) fd_xfer.push_back(blog.size());
            chk("out_valid", out_valid_a[cur], int'(q.size() != 0));
            chk("in_ready", in_ready_a[cur],
                int'(q.size() == 0 || (q.size() == 1 && out_ready_a[cur] && !q[0].pad)));
            if (stall) begin
                chk("stall_valid", out_valid_a[cur], 1);
                chk("stall_byte", out_byte_a[cur], stall_byte);
            end
            if (q.size() != 0) begin
                chk("out_byte", out_byte_a[cur], q[0].b);
                chk("out_last", out_last_a[cur], int'(q[0].last));
            end else begin
                chk("out_last_idle", out_last_a[cur], 0);
                idle_cnt++;
            end
            fd_exp = 0;
            stall = out_valid_a[cur] && !out_ready_a[cur];
            stall_byte = out_byte_a[cur];
            if (out_valid_a[cur] && out_ready_a[cur] && q.size() != 0) begin
                blog.push_back(out_byte_a[cur]);
                if (out_last_a[cur]) last_idx.push_back(blog.size());
                fd_exp = q[0].last;
                void'(q.pop_front());
            end
            in_fired = in_valid_a[cur] && in_ready_a[cur];
            if (in_fired) begin
                int w, h, pad, col, row;
                bit eor, eof;
                ent_t e;
                w = tw(cur); h = th(cur); pad = w % 4;
                col = pix_n % w; row = (pix_n / w) % h;
                eor = (col == w - 1);
                eof = eor && (row == h - 1);
                ifire.push_back(cyc);
                for (int i = 0; i < 3; i++) begin
                    e.b = in_pixel_a[cur][8*i +: 8];
                    e.last = eof && (pad == 0) && (i == 2);
                    e.pad = 0;
                    q.push_back(e);
                end
                if (eor) begin
                    for (int i = 0; i < pad; i++) begin
                        e.b = 8'h00;
                        e.last = eof && (i == pad - 1);
                        e.pad = 1;
                        q.push_back(e);
                    end
                end
                pix_n++;
            end
        end
    end

    task automatic do_reset(input int k);
        @(posedge clk); #1;
        reset = 1'b1;
        cur = k;
        for (int i = 0; i < NT; i++) begin
            in_valid_a[i] = 1'b0;
            out_ready_a[i] = 1'b1;
        end
        src.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Drives src into the active instance; stops early after stopb bytes if stopb > 0.
    task automatic run(input int maxc, input int stopb);
        int c;
        int g;
        int pat[7];
        pat = '{0, 1, 0, 0, 1, 1, 1};
        c = 0; g = 0;
        while (1) begin
            @(posedge clk); #1;
            if (in_fired) begin
                void'(src.pop_front());
                g = rnd_gap ? int'($urandom_range(0, 4)) : gapn;
            end else if (g > 0) begin
                g--;
            end
            in_valid_a[cur] = (src.size() != 0) && (g == 0);
            in_pixel_a[cur] = (src.size() != 0) ? src[0] : 24'h0;
            case (or_mode)
                1:       out_ready_a[cur] = (c >= 1 && c <= 7) ? pat[c-1][0] : 1'b1;
                2:       out_ready_a[cur] = 1'($urandom_range(0, 1));
                default: out_ready_a[cur] = 1'b1;
            endcase
            c++;
            if (stopb > 0 && blog.size() >= stopb) break;
            if (src.size() == 0 && q.size() == 0) begin
                out_ready_a[cur] = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                break;
            end
            if (c >= maxc) begin
                n_chk++; n_fail++;
                $display("FAIL run_budget: got %0d cycles expected under %0d (inst %0d)", c, maxc, cur);
                break;
            end
        end
        in_valid_a[cur] = 1'b0;
    endtask

    initial begin
        #(500000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e1 [12];
        logic [7:0] e2 [4];
        e1 = '{8'hCC, 8'hBB, 8'hAA, 8'hCC, 8'hBB, 8'hAA, 8'hCC, 8'hBB, 8'hAA, 8'h00, 8'h00, 8'h00};
        e2 = '{8'h33, 8'h22, 8'h11, 8'h00};
        for (int i = 0; i < NT; i++) begin
            in_valid_a[i] = 1'b0;
            in_pixel_a[i] = 24'h0;
            out_ready_a[i] = 1'b1;
        end
        #2;
        for (int i = 0; i < NT; i++) begin
            chk("init_in_ready", in_ready_a[i], 1);
            chk("init_out_valid", out_valid_a[i], 0);
            chk("init_out_byte", out_byte_a[i], 0);
        end

        // Throughput and byte order, W=4 H=2
        do_reset(0);
        or_mode = 0; gapn = 0; rnd_gap = 0;
        for (int i = 0; i < 8; i++) src.push_back({8'(3*i+3), 8'(3*i+2), 8'(3*i+1)});
        run(400, 0);
        chk("t0_bytes", blog.size(), 24);
        for (int i = 0; i < blog.size(); i++) chk("t0_byte_val", blog[i], i + 1);
        chk("t0_last_cnt", last_idx.size(), 1);
        if (last_idx.size() != 0) chk("t0_last_pos", last_idx[0], 24);
        chk("t0_fd_cnt", fd_xfer.size(), 1);
        for (int i = 1; i < ifire.size(); i++) chk("t0_in_spacing", ifire[i] - ifire[i-1], 3);

        // Padding, W=3 H=1
        do_reset(1);
        for (int i = 0; i < 3; i++) src.push_back(24'hAABBCC);
        run(400, 0);
        chk("t1_bytes", blog.size(), 12);
        for (int i = 0; i < 12 && i < blog.size(); i++) chk("t1_byte_val", blog[i], e1[i]);
        if (last_idx.size() != 0) chk("t1_last_pos", last_idx[0], 12);
        chk("t1_fd_cnt", fd_xfer.size(), 1);

        // Backpressure, W=1 H=1
        do_reset(2);
        or_mode = 1;
        src.push_back(24'h112233);
        run(400, 0);
        chk("t2_bytes", blog.size(), 4);
        for (int i = 0; i < 4 && i < blog.size(); i++) chk("t2_byte_val", blog[i], e2[i]);
        if (last_idx.size() != 0) chk("t2_last_pos", last_idx[0], 4);
        chk("t2_fd_cnt", fd_xfer.size(), 1);

        // Input starvation, W=2 H=2
        do_reset(3);
        or_mode = 0; gapn = 5;
        for (int i = 0; i < 4; i++) src.push_back(24'($urandom));
        run(400, 0);
        chk("t3_bytes", blog.size(), 16);
        if (blog.size() == 16) begin
            chk("t3_pad0", blog[6], 0);
            chk("t3_pad1", blog[7], 0);
            chk("t3_pad2", blog[14], 0);
            chk("t3_pad3", blog[15], 0);
        end
        chk("t3_idle_seen", int'(idle_cnt >= 5), 1);

        // Two frames back to back, W=5 H=3
        do_reset(4);
        gapn = 0;
        for (int i = 0; i < 30; i++) src.push_back(24'($urandom));
        run(1000, 0);
        chk("t4_bytes", blog.size(), 96);
        chk("t4_fd_cnt", fd_xfer.size(), 2);
        if (fd_xfer.size() == 2) begin
            chk("t4_fd_first", fd_xfer[0], 48);
            chk("t4_fd_gap", fd_xfer[1] - fd_xfer[0], 48);
        end

        // Random gaps and random backpressure, W=5 H=3
        do_reset(4);
        or_mode = 2; rnd_gap = 1;
        for (int i = 0; i < 40; i++) src.push_back(24'($urandom));
        run(3000, 0);
        chk("t5_bytes", blog.size(), 128);
        chk("t5_fd_cnt", fd_xfer.size(), 2);
        or_mode = 0; rnd_gap = 0;

        // Reset in the middle of a row, W=4 H=2
        do_reset(0);
        for (int i = 0; i < 8; i++) src.push_back({8'(3*i+3), 8'(3*i+2), 8'(3*i+1)});
        run(400, 5);
        reset = 1'b1;
        in_valid_a[0] = 1'b0;
        #1;
        chk("async_out_valid", out_valid_a[0], 0);
        chk("async_out_byte", out_byte_a[0], 0);
        chk("async_out_last", out_last_a[0], 0);
        chk("async_frame_done", frame_done_a[0], 0);
        chk("async_in_ready", in_ready_a[0], 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        src.delete();
        for (int i = 0; i < 8; i++) src.push_back({8'(3*i+3), 8'(3*i+2), 8'(3*i+1)});
        run(400, 0);
        chk("t6_bytes", blog.size(), 24);
        if (blog.size() != 0) chk("t6_first_byte", blog[0], 1);
        chk("t6_last_cnt", last_idx.size(), 1);
        if (last_idx.size() != 0) chk("t6_last_pos", last_idx[0], 24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
